// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path definitions: memory access encodings and the buffered fetch entry.
package fetch_unit_pkg;

  localparam logic [1:0] sz_byte = 2'd0;
  localparam logic [1:0] sz_half = 2'd1;
  localparam logic [1:0] sz_word = 2'd2;

  localparam logic rd_wr_read = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order synchronous FIFO of fetch entries with flush; storage is not reset, only pointers.
module fetch_fifo import fetch_unit_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  entry_t          wdata,
  output entry_t          rdata,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC ownership, credit-limited pipelined reads, redirect with
// stale-response discard, and an in-order buffer towards decode.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter logic [ADDR_W-1:0] PC_INIT         = '0,
  parameter int unsigned       FIFO_DEPTH      = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_rd_wr,
  output logic [1:0]        mem_access_size,
  input  logic              mem_busy,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redirect_aligned;
  logic [OutW-1:0]   outstanding_q, outstanding_d, discard_q, discard_d;
  logic              accept, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  entry_t            fifo_wdata, fifo_rdata;
  logic              unused_bits;

  assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_bits      = ^{redirect_pc[1:0], fifo_full};

  // Credit rule: every accepted read already owns a FIFO slot for its response.
  assign mem_enable = !reset && !redirect_valid
                      && (32'(outstanding_q) < MAX_OUTSTANDING)
                      && ((32'(fifo_count) + 32'(outstanding_q)) < FIFO_DEPTH);
  assign accept          = mem_enable & ~mem_busy;
  assign mem_addr        = fetch_pc_q;
  assign fetch_pc        = fetch_pc_q;
  assign mem_rd_wr       = rd_wr_read;
  assign mem_access_size = sz_word;

  assign fifo_push  = mem_rvalid && !redirect_valid && (discard_q == '0);
  assign fifo_pop   = instr_valid && instr_ready && !redirect_valid;
  assign fifo_wdata = '{instr: mem_rdata, pc: resp_pc_q};

  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_empty ? '0 : fifo_rdata.instr;
  assign instr_pc    = fifo_empty ? '0 : fifo_rdata.pc;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + OutW'(accept) - OutW'(mem_rvalid);
    discard_d     = discard_q;
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path.
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      discard_d  = outstanding_q - OutW'(mem_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (mem_rvalid) begin
        if (discard_q != '0) discard_d = discard_q - OutW'(1);
        else                 resp_pc_d = resp_pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= PC_INIT;
      resp_pc_q     <= PC_INIT;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected requests/instructions,
// a negedge monitor pops and compares, and a small in-order memory model answers reads.
module tb_fetch_unit;

  localparam logic [31:0] PcInit = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_enable, mem_rd_wr;
  logic [1:0]  mem_access_size;
  logic        mem_busy = 1'b0;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr, instr_pc, fetch_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .PC_INIT         (PcInit),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_addr        (mem_addr),
    .mem_enable      (mem_enable),
    .mem_rd_wr       (mem_rd_wr),
    .mem_access_size (mem_access_size),
    .mem_busy        (mem_busy),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .fetch_pc        (fetch_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       mem_pend[$];
  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  int cyc = 0, lat = 1, n_acc = 0, n_deliv = 0, n_checks = 0, n_fail = 0;
  int base_acc, base_deliv;
  logic [31:0] held;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_stream(input logic [31:0] pc, input int n);
    exp_req.delete();
    exp_pc.delete();
    for (int i = 0; i < n; i++) begin
      exp_req.push_back(pc + 32'(4 * i));
      exp_pc.push_back(pc + 32'(4 * i));
    end
  endtask

  task automatic do_redirect(input logic [31:0] target, input int n);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    start_stream({target[31:2], 2'b00}, n);
    #1;
    check("redir_no_issue", 32'(mem_enable), 32'd0);
    tick();
    redirect_valid = 1'b0;
  endtask

  // Memory: in-order responses, one per cycle, no earlier than lat cycles after acceptance.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mem_rvalid = 1'b0;
      if (mem_pend.size() > 0 && mem_pend[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(mem_pend[0].addr);
        mem_pend.delete(0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_pend.delete();
      end else begin
        if (mem_enable && !mem_busy) begin
          n_acc++;
          mem_pend.push_back('{addr: mem_addr, due: cyc + lat});
          if (exp_req.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: got %h, none expected", mem_addr);
          end else begin
            check("req_addr", mem_addr, exp_req[0]);
            exp_req.delete(0);
          end
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
          n_deliv++;
          if (exp_pc.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL instr_unexpected: got pc %h, none expected", instr_pc);
          end else begin
            check("instr_pc", instr_pc, exp_pc[0]);
            check("instr", instr, mem_word(exp_pc[0]));
            exp_pc.delete(0);
          end
        end
        if (dut.fifo_full) check("fifo_overflow", 32'(dut.fifo_push && !dut.fifo_pop), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset and first consecutive requests
    tick();
    tick();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_enable", 32'(mem_enable), 32'd0);
    tick();
    check("rst_valid2", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_fetch_pc", fetch_pc, PcInit);
    check("rd_wr", 32'(mem_rd_wr), 32'd1);
    check("access_size", 32'(mem_access_size), 32'd2);
    reset = 1'b0;
    start_stream(PcInit, 32);
    #1;
    check("p1_enable0", 32'(mem_enable), 32'd1);
    check("p1_addr0", mem_addr, PcInit);
    for (int i = 1; i < 3; i++) begin
      tick();
      check("p1_enable", 32'(mem_enable), 32'd1);
      check("p1_addr", mem_addr, PcInit + 32'(4 * i));
      check("p1_valid", 32'(instr_valid), 32'(i == 2));
    end
    check("p1_first_pc", instr_pc, PcInit);
    repeat (8) tick();
    check("p1_deliv", 32'(n_deliv >= 8), 32'd1);

    // Stall: FIFO fills, issue stops, release drains in order
    reset = 1'b1;
    instr_ready = 1'b0;
    start_stream(PcInit, 0);
    tick();
    tick();
    reset = 1'b0;
    start_stream(PcInit, 48);
    base_acc = n_acc;
    repeat (10) tick();
    check("p2_accepts", 32'(n_acc - base_acc), 32'd4);
    check("p2_enable", 32'(mem_enable), 32'd0);
    check("p2_count", 32'(dut.fifo_count), 32'd4);
    instr_ready = 1'b1;
    base_deliv = n_deliv;
    repeat (8) tick();
    check("p2_drain", 32'(n_deliv - base_deliv >= 5), 32'd1);

    // Memory busy holds the fetch address
    mem_busy = 1'b1;
    held = mem_addr;
    base_acc = n_acc;
    repeat (3) begin
      tick();
      check("p3_addr_hold", mem_addr, held);
      check("p3_pc_hold", fetch_pc, held);
    end
    check("p3_no_accept", 32'(n_acc - base_acc), 32'd0);
    mem_busy = 1'b0;
    #1;
    check("p3_resume_en", 32'(mem_enable), 32'd1);
    check("p3_resume_addr", mem_addr, held);
    repeat (6) tick();

    // Redirect with 2 reads outstanding and 2 entries buffered
    reset = 1'b1;
    instr_ready = 1'b0;
    start_stream(PcInit, 0);
    tick();
    tick();
    lat = 3;
    reset = 1'b0;
    start_stream(PcInit, 16);
    base_acc = n_acc;
    for (int k = 0; k < 20 && (n_acc - base_acc) < 4; k++) tick();
    check("p4_accepts", 32'(n_acc - base_acc), 32'd4);
    check("p4_buffered", 32'(dut.fifo_count), 32'd2);
    check("p4_outstanding", 32'(dut.outstanding_q), 32'd2);
    do_redirect(32'h0000_1003, 32);
    instr_ready = 1'b1;
    check("p4_flushed", 32'(instr_valid), 32'd0);
    check("p4_fetch_pc", fetch_pc, 32'h0000_1000);
    check("p4_discard", 32'(dut.discard_q), 32'd2);

    // Redirect coinciding with a response and a ready handshake
    for (int k = 0; k < 20 && !(mem_rvalid && instr_valid); k++) tick();
    check("p5_found", 32'(mem_rvalid && instr_valid), 32'd1);
    base_acc = n_acc;
    base_deliv = n_deliv;
    do_redirect(32'h0000_2000, 32);
    check("p5_no_accept", 32'(n_acc - base_acc), 32'd0);
    check("p5_no_deq", 32'(n_deliv - base_deliv), 32'd0);
    check("p5_flushed", 32'(instr_valid), 32'd0);
    repeat (12) tick();

    // Back-to-back redirects, the later one wins
    base_deliv = n_deliv;
    do_redirect(32'h0000_3000, 8);
    do_redirect(32'h0000_5008, 32);
    repeat (15) tick();
    check("p5_b2b_deliv", 32'(n_deliv - base_deliv >= 3), 32'd1);

    // PC wrap, then reset mid-stream
    lat = 1;
    do_redirect(32'hFFFF_FFF8, 32);
    check("p6_fetch_pc", fetch_pc, 32'hFFFF_FFF8);
    base_acc = n_acc;
    repeat (6) tick();
    check("p6_wrap_accepts", 32'(n_acc - base_acc >= 3), 32'd1);
    reset = 1'b1;
    start_stream(PcInit, 0);
    tick();
    check("p6_rst_pc", fetch_pc, PcInit);
    check("p6_rst_valid", 32'(instr_valid), 32'd0);
    check("p6_rst_enable", 32'(mem_enable), 32'd0);
    tick();
    reset = 1'b0;
    start_stream(PcInit, 32);
    base_deliv = n_deliv;
    repeat (8) tick();
    check("p6_restart_deliv", 32'(n_deliv - base_deliv >= 4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
